// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the fetch bus, the data bus, the arbiter and the external memory port.
// The master modport is the arbiter's view; slave is the core/memory side.
interface mem_bus_arbiter_if;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic [31:0] ibus_rdata;
    logic        ibus_ok;

    logic        dbus_req;
    logic [3:0]  dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ok;

    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport master (
        input  ibus_req, ibus_addr,
        output ibus_rdata, ibus_ok,
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata,
        output dbus_rdata, dbus_ok,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        output ibus_req, ibus_addr,
        input  ibus_rdata, ibus_ok,
        output dbus_req, dbus_we, dbus_addr, dbus_wdata,
        input  dbus_rdata, dbus_ok,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like memory port between the fetch bus and the data bus, one transaction at a time.
// dbus wins arbitration; a streak counter hands ibus the next grant after STARVE_LIMIT dbus wins.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_bus_arbiter_if.master     bus
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state;
    state_t      state_next;
    logic        owner;
    logic [3:0]  we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  streak;

    logic        starve;
    logic        grant_dbus;
    logic        grant_ibus;
    logic        complete;

    always_comb begin
        state_next = state;
        grant_dbus = 1'b0;
        grant_ibus = 1'b0;
        complete   = 1'b0;
        starve     = bus.ibus_req && (streak == LIMIT);
        unique case (state)
            IDLE: begin
                if (bus.dbus_req && !starve) begin
                    grant_dbus = 1'b1;
                    state_next = ADDR;
                end else if (bus.ibus_req) begin
                    grant_ibus = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                // data_ok without addr_ok cannot belong to this request, so it is ignored
                if (bus.mem_addr_ok) begin
                    if (bus.mem_data_ok) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (bus.mem_data_ok) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            we_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            streak  <= 4'd0;
        end else begin
            state <= state_next;
            if (grant_dbus) begin
                owner   <= 1'b1;
                we_q    <= bus.dbus_we;
                addr_q  <= bus.dbus_addr;
                wdata_q <= bus.dbus_wdata;
                // the streak only grows while a fetch is actually waiting
                if (bus.ibus_req)
                    streak <= (streak == LIMIT) ? LIMIT : streak + 4'd1;
                else
                    streak <= 4'd0;
            end else if (grant_ibus) begin
                owner   <= 1'b0;
                we_q    <= 4'd0;
                addr_q  <= bus.ibus_addr;
                wdata_q <= 32'd0;
                streak  <= 4'd0;
            end
        end
    end

    // memory side is driven only from latched fields, never from requester inputs
    assign bus.mem_req   = (state == ADDR);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.ibus_ok    = complete && !owner;
    assign bus.dbus_ok    = complete && owner;
    assign bus.ibus_rdata = bus.ibus_ok ? bus.mem_rdata : 32'd0;
    assign bus.dbus_rdata = bus.dbus_ok ? bus.mem_rdata : 32'd0;

endmodule
